// File: rtl/seq_mux.sv
// seq_mux: registered CH-channel multiplexer with a channel sequencer.
// Manual mode follows i_sel; auto mode scans channels round-robin,
// spending DWELL cycles on each one. Every output comes straight from a
// flop, so there is no combinational path from any input to any output.
module seq_mux #(
  parameter  int WIDTH = 4,
  parameter  int CH    = 4,
  parameter  int DWELL = 4,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [CH*WIDTH-1:0]   i_data,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_hold,
  output logic [WIDTH-1:0]      o_data,
  output logic [SEL_W-1:0]      o_ch,
  output logic                  o_chg
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CH - 1);
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CH);

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  logic [SEL_W-1:0] r_cur;
  logic [CNT_W-1:0] r_cnt;
  mode_e            r_lastMode;

  logic [SEL_W-1:0] w_nxt;
  logic [CNT_W-1:0] w_cntNxt;
  logic [CNT_W-1:0] w_cntEff;
  logic [WIDTH-1:0] w_nxtData;

  // Next channel and dwell count; the first auto cycle after manual always
  // starts its dwell from zero, and out-of-range selects keep the channel.
  always_comb begin
    w_nxt    = r_cur;
    w_cntNxt = '0;
    w_cntEff = (r_lastMode == MODE_AUTO) ? r_cnt : '0;
    if (i_mode == 1'b0) begin
      if ({1'b0, i_sel} < CH_LIM) begin
        w_nxt = i_sel;
      end
    end else if (i_hold) begin
      w_cntNxt = w_cntEff;
    end else if (w_cntEff == LAST_CNT) begin
      w_cntNxt = '0;
      w_nxt    = (r_cur == LAST_CH) ? '0 : r_cur + 1'b1;
    end else begin
      w_cntNxt = w_cntEff + 1'b1;
    end
  end

  // Pick the data slice belonging to the channel that will be current next.
  always_comb begin
    w_nxtData = '0;
    for (int k = 0; k < CH; k++) begin
      if (w_nxt == SEL_W'(k)) begin
        w_nxtData = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Sequencer state plus registered outputs; reset aborts any scan at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cur      <= '0;
      r_cnt      <= '0;
      r_lastMode <= MODE_MANUAL;
      o_data     <= '0;
      o_chg      <= 1'b0;
    end else begin
      r_cur      <= w_nxt;
      r_cnt      <= w_cntNxt;
      r_lastMode <= mode_e'(i_mode);
      o_data     <= w_nxtData;
      o_chg      <= (w_nxt != r_cur);
    end
  end

  assign o_ch = r_cur;

endmodule

// File: tb/tb_seq_mux.sv
// tb_seq_mux: directed, table-driven bench for seq_mux. Three instances
// cover the default geometry, a non-power-of-two channel count and DWELL=1.
module tb_seq_mux;

  logic clk = 1'b0;
  logic rst;

  // Instance A: WIDTH=4, CH=4, DWELL=4
  logic [15:0] aData;
  logic        aMode, aHold, aOChg;
  logic [1:0]  aSel, aOCh;
  logic [3:0]  aOData;

  // Instance B: WIDTH=4, CH=3, DWELL=2
  logic [11:0] bData;
  logic        bMode, bHold, bOChg;
  logic [1:0]  bSel, bOCh;
  logic [3:0]  bOData;

  // Instance C: WIDTH=4, CH=4, DWELL=1
  logic [15:0] cData;
  logic        cMode, cHold, cOChg;
  logic [1:0]  cSel, cOCh;
  logic [3:0]  cOData;

  int assertCount = 0;
  int errCount    = 0;

  typedef struct {
    int          dut;
    logic        mode;
    logic [1:0]  sel;
    logic        hold;
    logic [15:0] data;
    logic [1:0]  expCh;
    logic [3:0]  expData;
    logic        expChg;
  } vec_t;

  vec_t vecs[$];

  seq_mux #(.WIDTH(4), .CH(4), .DWELL(4)) dutA (
    .i_clk(clk), .i_rst(rst), .i_data(aData), .i_mode(aMode), .i_sel(aSel),
    .i_hold(aHold), .o_data(aOData), .o_ch(aOCh), .o_chg(aOChg));

  seq_mux #(.WIDTH(4), .CH(3), .DWELL(2)) dutB (
    .i_clk(clk), .i_rst(rst), .i_data(bData), .i_mode(bMode), .i_sel(bSel),
    .i_hold(bHold), .o_data(bOData), .o_ch(bOCh), .o_chg(bOChg));

  seq_mux #(.WIDTH(4), .CH(4), .DWELL(1)) dutC (
    .i_clk(clk), .i_rst(rst), .i_data(cData), .i_mode(cMode), .i_sel(cSel),
    .i_hold(cHold), .o_data(cOData), .o_ch(cOCh), .o_chg(cOChg));

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if something stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: timeout reached, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void addVec(int dut, logic mode, logic [1:0] sel, logic hold,
                                 logic [15:0] data, logic [1:0] ch, logic [3:0] d,
                                 logic chg);
    vec_t v;
    v.dut = dut; v.mode = mode; v.sel = sel; v.hold = hold; v.data = data;
    v.expCh = ch; v.expData = d; v.expChg = chg;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    assertCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one vector onto its instance and advance one clock edge
  task automatic applyStimulus(input vec_t v);
    case (v.dut)
      0: begin aMode = v.mode; aSel = v.sel; aHold = v.hold; aData = v.data; end
      1: begin bMode = v.mode; bSel = v.sel; bHold = v.hold; bData = v.data[11:0]; end
      default: begin cMode = v.mode; cSel = v.sel; cHold = v.hold; cData = v.data; end
    endcase
    @(posedge clk);
    #1;
  endtask

  // Compare the addressed instance against the expected fields of a vector
  task automatic checkOutput(input vec_t v, input int idx);
    logic [1:0] ch;
    logic [3:0] d;
    logic       chg;
    case (v.dut)
      0:       begin ch = aOCh; d = aOData; chg = aOChg; end
      1:       begin ch = bOCh; d = bOData; chg = bOChg; end
      default: begin ch = cOCh; d = cOData; chg = cOChg; end
    endcase
    check($sformatf("vec%0d o_ch", idx),   {6'd0, ch},  {6'd0, v.expCh});
    check($sformatf("vec%0d o_data", idx), {4'd0, d},   {4'd0, v.expData});
    check($sformatf("vec%0d o_chg", idx),  {7'd0, chg}, {7'd0, v.expChg});
  endtask

  task automatic checkA(input string tag, input logic [1:0] ch, input logic [3:0] d, input logic chg);
    check({tag, " o_ch"},   {6'd0, aOCh},   {6'd0, ch});
    check({tag, " o_data"}, {4'd0, aOData}, {4'd0, d});
    check({tag, " o_chg"},  {7'd0, aOChg},  {7'd0, chg});
  endtask

  initial begin
    // ---------------- vector table ----------------
    // A: manual sweep over 16'hDCBA
    addVec(0, 0, 0, 0, 16'hDCBA, 0, 4'hA, 0);
    addVec(0, 0, 1, 0, 16'hDCBA, 1, 4'hB, 1);
    addVec(0, 0, 2, 0, 16'hDCBA, 2, 4'hC, 1);
    addVec(0, 0, 3, 0, 16'hDCBA, 3, 4'hD, 1);
    addVec(0, 0, 3, 0, 16'hDCBA, 3, 4'hD, 0);
    // A: data change on an unchanged channel
    addVec(0, 0, 3, 0, 16'h5CBA, 3, 4'h5, 0);
    addVec(0, 0, 2, 0, 16'h5CBA, 2, 4'hC, 1);
    // A: manual -> auto from channel 2, dwell 4, wrap 3 -> 0
    addVec(0, 1, 0, 0, 16'hDCBA, 2, 4'hC, 0);
    addVec(0, 1, 0, 0, 16'hDCBA, 2, 4'hC, 0);
    addVec(0, 1, 0, 0, 16'hDCBA, 2, 4'hC, 0);
    addVec(0, 1, 0, 0, 16'hDCBA, 3, 4'hD, 1);
    addVec(0, 1, 0, 0, 16'hDCBA, 3, 4'hD, 0);
    addVec(0, 1, 0, 0, 16'hDCBA, 3, 4'hD, 0);
    addVec(0, 1, 0, 0, 16'hDCBA, 3, 4'hD, 0);
    addVec(0, 1, 0, 0, 16'hDCBA, 0, 4'hA, 1);
    addVec(0, 1, 0, 0, 16'hDCBA, 0, 4'hA, 0);
    addVec(0, 1, 0, 0, 16'hDCBA, 0, 4'hA, 0);
    // A: hold for 5 cycles with cnt = 2 (i_sel ignored in auto)
    for (int i = 0; i < 5; i++) addVec(0, 1, 3, 1, 16'hDCBA, 0, 4'hA, 0);
    // A: release, cnt 2 -> 3, then advance
    addVec(0, 1, 0, 0, 16'hDCBA, 0, 4'hA, 0);
    addVec(0, 1, 0, 0, 16'hDCBA, 1, 4'hB, 1);
    // A: auto -> manual takes effect at once, i_hold ignored
    addVec(0, 0, 3, 1, 16'hDCBA, 3, 4'hD, 1);

    // B (CH=3): out-of-range select is ignored, data still tracked
    addVec(1, 0, 1, 0, 16'h0987, 1, 4'h8, 1);
    addVec(1, 0, 3, 0, 16'h0987, 1, 4'h8, 0);
    addVec(1, 0, 3, 0, 16'h09A7, 1, 4'hA, 0);
    // B: auto with dwell 2, wrap from 2 back to 0
    addVec(1, 1, 0, 0, 16'h0987, 1, 4'h8, 0);
    addVec(1, 1, 0, 0, 16'h0987, 2, 4'h9, 1);
    addVec(1, 1, 0, 0, 16'h0987, 2, 4'h9, 0);
    addVec(1, 1, 0, 0, 16'h0987, 0, 4'h7, 1);
    addVec(1, 1, 0, 0, 16'h0987, 0, 4'h7, 0);
    addVec(1, 0, 3, 0, 16'h0987, 0, 4'h7, 0);

    // C (DWELL=1): advance every edge with o_chg constantly high
    addVec(2, 1, 0, 0, 16'hDCBA, 1, 4'hB, 1);
    addVec(2, 1, 0, 0, 16'hDCBA, 2, 4'hC, 1);
    addVec(2, 1, 0, 0, 16'hDCBA, 3, 4'hD, 1);
    addVec(2, 1, 0, 0, 16'hDCBA, 0, 4'hA, 1);
    addVec(2, 1, 0, 0, 16'hDCBA, 1, 4'hB, 1);
    addVec(2, 1, 0, 0, 16'hDCBA, 2, 4'hC, 1);
    addVec(2, 0, 0, 0, 16'hDCBA, 0, 4'hA, 1);
    addVec(2, 0, 0, 0, 16'hDCBA, 0, 4'hA, 0);

    // ---------------- reset ----------------
    rst = 1'b1;
    aData = 16'hDCBA; aMode = 0; aSel = 0; aHold = 0;
    bData = 12'h987;  bMode = 0; bSel = 0; bHold = 0;
    cData = 16'hDCBA; cMode = 0; cSel = 0; cHold = 0;
    #2;
    checkA("reset A", 2'd0, 4'h0, 1'b0);
    check("reset B o_ch", {6'd0, bOCh}, 8'd0);
    check("reset C o_data", {4'd0, cOData}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---------------- table loop ----------------
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // ---------------- reset mid-scan ----------------
    aMode = 0; aSel = 2; aHold = 0;
    @(posedge clk); #1;
    aMode = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkA("prescan", 2'd2, 4'hC, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checkA("async reset", 2'd0, 4'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) checkA($sformatf("restart%0d", i), 2'd0, 4'hA, 1'b0);
      else       checkA($sformatf("restart%0d", i), 2'd1, 4'hB, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, errCount);
    $finish;
  end

endmodule
